// File: rtl/ref_particle_broadcaster.sv
// Walks ref particles 1..count of a home cell, reads each record and broadcasts it on valid/ready.
// Per-particle period RD_LATENCY+2 cycles; one read in flight; out_valid holds record until out_ready.
module ref_particle_broadcaster #(
  parameter int PARTICLE_ID_WIDTH = 7,
  parameter int DATA_WIDTH        = 96,
  parameter int RD_LATENCY        = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [PARTICLE_ID_WIDTH-1:0] particle_count,
  input  logic                         count_valid,
  output logic                         rd_en,
  output logic [PARTICLE_ID_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0]        rd_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PARTICLE_ID_WIDTH-1:0] out_id,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [PARTICLE_ID_WIDTH-1:0] ref_id,
  output logic                         broadcast_done,
  output logic                         busy
);

  localparam int LW = 3;
  localparam logic [PARTICLE_ID_WIDTH-1:0] ID_ONE = PARTICLE_ID_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_COUNT,
    READ,
    WAIT_DATA,
    SEND,
    DONE
  } state_t;

  state_t                         state_q, state_d;
  logic [PARTICLE_ID_WIDTH-1:0]   ref_id_q, ref_id_d;
  logic [PARTICLE_ID_WIDTH-1:0]   count_q, count_d;
  logic [PARTICLE_ID_WIDTH-1:0]   out_id_q, out_id_d;
  logic [LW-1:0]                  lat_q, lat_d;
  logic [DATA_WIDTH-1:0]          out_data_q, out_data_d;

  always_comb begin
    state_d    = state_q;
    ref_id_d   = ref_id_q;
    count_d    = count_q;
    out_id_d   = out_id_q;
    lat_d      = lat_q;
    out_data_d = out_data_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = WAIT_COUNT;
          ref_id_d = ID_ONE;
        end
      end
      WAIT_COUNT: begin
        if (count_valid) begin
          count_d = particle_count;
          state_d = (particle_count == '0) ? DONE : READ;
        end
      end
      READ: begin
        // Counter reaches zero in the cycle rd_data is valid.
        lat_d   = LW'(RD_LATENCY - 1);
        state_d = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (lat_q == '0) begin
          out_data_d = rd_data;
          out_id_d   = ref_id_q;
          state_d    = SEND;
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      SEND: begin
        if (out_ready) begin
          ref_id_d = ref_id_q + ID_ONE;
          state_d  = (ref_id_q == count_q) ? DONE : READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ref_id_q   <= '0;
      count_q    <= '0;
      out_id_q   <= '0;
      lat_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ref_id_q   <= ref_id_d;
      count_q    <= count_d;
      out_id_q   <= out_id_d;
      lat_q      <= lat_d;
      out_data_q <= out_data_d;
    end
  end

  assign rd_en          = (state_q == READ);
  assign rd_addr        = rd_en ? (ref_id_q - ID_ONE) : '0;
  assign out_valid      = (state_q == SEND);
  assign out_id         = out_id_q;
  assign out_data       = out_data_q;
  assign ref_id         = ref_id_q;
  assign broadcast_done = (state_q == DONE);
  assign busy           = (state_q != IDLE) && (state_q != DONE);

endmodule

// File: doc/ref_particle_broadcaster.md
# ref_particle_broadcaster

Sequencer that walks the reference particles of one home cell and broadcasts each one to the downstream filter/force pipelines. It sits upstream of the broadcast-done check. It issues ref_id values from 1 up to particle_count and reads each particle's record from cell memory. It presents each record on a valid/ready output. It ends with ref_id = particle_count + 1 and a done flag raised.

## Interface
- PARTICLE_ID_WIDTH, 7, width of particle IDs and counts; IDs are 1-based.
- DATA_WIDTH, 96, particle record width (x/y/z, 32 bits each).
- RD_LATENCY, 2, cell memory read latency in cycles; legal range 1..7.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a cell pass; honoured only in IDLE or DONE.
- particle_count  in  PARTICLE_ID_WIDTH  particles in the cell; sampled only when count_valid=1.
- count_valid  in  1  particle_count is valid this cycle.
- rd_en  out  1  cell memory read strobe.
- rd_addr  out  PARTICLE_ID_WIDTH  read address, equal to ref_id − 1.
- rd_data  in  DATA_WIDTH  memory data, valid RD_LATENCY cycles after rd_en.
- out_valid  out  1  broadcast record valid.
- out_ready  in  1  downstream accepts.
- out_id  out  PARTICLE_ID_WIDTH  ID of the broadcast particle.
- out_data  out  DATA_WIDTH  broadcast particle record.
- ref_id  out  PARTICLE_ID_WIDTH  current reference particle ID.
- broadcast_done  out  1  all particles of the cell have been accepted.
- busy  out  1  high in any state other than IDLE and DONE.

## Operation
- States: IDLE, WAIT_COUNT, READ, WAIT_DATA, SEND, DONE.
- IDLE/DONE + start: go to WAIT_COUNT, set ref_id=1, clear broadcast_done.
- WAIT_COUNT: stay until count_valid=1, then latch particle_count into an internal count.
  - count=0: go to DONE; ref_id stays 1 (1 > 0).
  - count≠0: go to READ.
- READ: rd_en=1 and rd_addr=ref_id−1 for exactly one cycle, then go to WAIT_DATA. A latency counter is loaded at this point.
- WAIT_DATA: count RD_LATENCY cycles. In the cycle rd_data is valid, register it into out_data, set out_id=ref_id, go to SEND.
- SEND: out_valid=1, with out_data/out_id stable, until out_valid&out_ready.
  - On the accepting cycle, ref_id increments.
  - If the old ref_id equalled count, go to DONE; otherwise go to READ.
- DONE: broadcast_done=1, ref_id=count+1. Hold until start or rst.
- count_valid outside WAIT_COUNT is ignored. particle_count changes after latching have no effect.
- start outside IDLE/DONE is ignored.
- ref_id arithmetic is PARTICLE_ID_WIDTH bits. count = 2^W−1 is not supported: ref_id would wrap to 0. The maximum supported count is 2^W−2, which gives a final ref_id of 2^W−1.
- Reset values: state=IDLE, ref_id=0, rd_en=0, rd_addr=0, out_valid=0, out_id=0, out_data=0, broadcast_done=0, busy=0. Reset mid-pass aborts immediately; no further rd_en or out_valid is issued.

## Timing
- start in cycle s gives WAIT_COUNT in s+1. count_valid in cycle c≥s+1 gives rd_en in c+1.
- rd_en in cycle r, data captured at r+RD_LATENCY, out_valid from r+RD_LATENCY+1.
- Acceptance in cycle a gives the next rd_en in a+1, or broadcast_done=1 in a+1.
- Per-particle period with out_ready held high is RD_LATENCY+2 cycles.
- Only one read is outstanding at a time. No read is issued while out_valid=1.

## Test plan
- RD_LATENCY=2, start@0, count_valid@3 with count=3, out_ready=1.
  - Required: rd_en@4/8/12 with addr 0/1/2; out_valid@7/11/15 with out_id 1/2/3; broadcast_done=1 and ref_id=4 from cycle 16.
- Same setup, but out_ready low in cycles 7..10.
  - Required: out_valid held with out_id=1 and data stable; accepted@11; next rd_en@12; done@20.
- count_valid with count=0.
  - Required: no rd_en and no out_valid; broadcast_done=1 and ref_id=1 one cycle later.
- start pulses during SEND, and count_valid changing to 9 mid-pass.
  - Required: both ignored; the pass completes with the original count.
  - start after DONE: broadcast_done drops next cycle and the pass restarts at ref_id=1.
- rst asserted during WAIT_DATA of particle 2.
  - Required: next cycle all outputs at reset values; state IDLE; no out_valid for particle 2.
- count=126, W=7, out_ready random.
  - Required: exactly 126 accepted transfers with IDs 1..126 in order; final ref_id=127; done asserted.
